// File: rtl/register_read_sequencer_pkg.sv
// register_read_pkg: shared data width, sequencer state encoding and one-hot select helper
package register_read_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, CHECK, RESP} state_t;
  function automatic logic [DATA_W-1:0] onehot(input logic [DATA_W-1:0] addr, input int n);
    return (int'(addr) < n) ? DATA_W'(1) << addr : '0;
  endfunction
endpackage

// File: rtl/register_read_sequencer_if.sv
// register_read_sequencer_if: request/ack, register select, read bus and valid/ready response bundle (master = control unit, slave = sequencer)
interface register_read_sequencer_if #(parameter int NUM_REGS = 8, parameter int ADDR_W = 3);
  import register_read_pkg::*;
  logic req;
  logic [ADDR_W-1:0] addr;
  logic ack;
  logic [NUM_REGS-1:0] sel;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] rdata;
  logic rvalid;
  logic rready;
  logic err;
  logic mismatch;
  logic busy;
  modport master (output req, addr, bus_in, rready, input ack, sel, rdata, rvalid, err, mismatch, busy);
  modport slave (input req, addr, bus_in, rready, output ack, sel, rdata, rvalid, err, mismatch, busy);
endinterface

// File: rtl/register_read_sequencer_settle_counter.sv
// settle_counter: loads SETTLE_CYCLES-1 on load, counts down while dec, zero flags expiry
module settle_counter #(
  parameter int SETTLE_CYCLES = 2,
  localparam int W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(SETTLE_CYCLES - 1);
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/register_read_sequencer.sv
// register_read_sequencer: drives one-hot sel for a settle time, captures bus_in, returns it on rvalid/rready via bus (slave); clk/rst plain; REGISTER_READ_STABLE_CHECK_EN adds a CHECK resample setting mismatch
module register_read_sequencer
  import register_read_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  register_read_sequencer_if.slave bus
);
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (NUM_REGS < 2 || NUM_REGS > 16 || (1 << ADDR_W) < NUM_REGS) begin : g_bad_regs
    $error("NUM_REGS must be 2..16 and fit in ADDR_W");
  end
  state_t state;
  logic zero;
  logic mism;
  assign bus.ack = bus.req && state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.mismatch = mism;
  settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk(clk),
    .rst(rst),
    .load(bus.ack),
    .dec(state == SETTLE),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.sel <= '0;
      bus.rdata <= '0;
      bus.rvalid <= 1'b0;
      bus.err <= 1'b0;
      mism <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state <= SETTLE;
            bus.sel <= NUM_REGS'(onehot(DATA_W'(bus.addr), NUM_REGS));
          end
        end
        SETTLE: if (zero) state <= CAPTURE;
        CAPTURE: begin
          bus.rdata <= |bus.sel ? bus.bus_in : '0;
`ifdef REGISTER_READ_STABLE_CHECK_EN
          state <= CHECK;
`else
          state <= RESP;
          bus.sel <= '0;
          bus.rvalid <= 1'b1;
          bus.err <= ~|bus.sel;
`endif
        end
`ifdef REGISTER_READ_STABLE_CHECK_EN
        CHECK: begin
          state <= RESP;
          bus.sel <= '0;
          bus.rvalid <= 1'b1;
          bus.err <= ~|bus.sel;
          mism <= |bus.sel && bus.bus_in != bus.rdata;
        end
`endif
        RESP: begin
          if (bus.rready) begin
            state <= IDLE;
            bus.rvalid <= 1'b0;
            bus.err <= 1'b0;
            mism <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
